// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debounce
//  Purpose  : Multi-channel debouncer for the DE2 slide switches and keys.
//             Each channel is synchronised into clk by two flops. A channel
//             accepts a new level only after DEBOUNCE_CYCLES consecutive
//             cycles in which the synchronised input differs from the
//             current debounced level. Any return to the current level
//             restarts the count from zero.
//             For every channel the block provides a clean level, one-cycle
//             rise/fall pulses and an optional sticky event flag.
//
//  Parameters:
//    WIDTH           - number of independent channels
//    DEBOUNCE_CYCLES - stable cycles needed to accept a new level (>= 2)
//    CNT_WIDTH       - derived counter width, not meant to be overridden
//
//  Ports:
//    clk        in   system clock
//    rstN       in   asynchronous active-low reset
//    din        in   [WIDTH] raw asynchronous switch/button levels
//    clear      in   [WIDTH] level-sensitive synchronous clear of event_flag
//    dout       out  [WIDTH] debounced level
//    rise       out  [WIDTH] one-cycle pulse on an accepted 0->1 change
//    fall       out  [WIDTH] one-cycle pulse on an accepted 1->0 change
//    event_flag out  [WIDTH] sticky change flag. It is held until cleared.
//                            A change on the same edge as a clear wins.
//                            The flag cannot be called "event" because that
//                            is a reserved word in SystemVerilog.
//
//  Build option:
//    SWITCH_DEBOUNCE_EVENT_EN - when defined, the sticky event registers and
//                               the clear logic are built. When undefined,
//                               event_flag is tied to 0 and clear is ignored.
//
//  Revision : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] event_flag
);

    // Terminal count. When the counter reaches this value, the current
    // mismatch cycle is cycle number DEBOUNCE_CYCLES, so the new level is
    // accepted on this edge.
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] w_accept;

    // Two-flop synchroniser for the asynchronous board inputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    // Per-channel stability counter. The counter only runs while the
    // synchronised input disagrees with dout. It clears on agreement and
    // on acceptance, so it never passes c_CNT_MAX and cannot wrap.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 w_mismatch;

        assign w_mismatch   = r_s2[gi] ^ r_dout[gi];
        assign w_accept[gi] = w_mismatch && (r_cnt == c_CNT_MAX);

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                r_cnt <= '0;
            end else if (!w_mismatch || w_accept[gi]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Accepting a level always flips dout. The new level is r_s2, so the
    // direction of the pulse comes straight from r_s2. This means rise and
    // fall can never both be high on one channel.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_dout <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_dout <= r_dout ^ w_accept;
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;

`ifdef SWITCH_DEBOUNCE_EVENT_EN
    logic [WIDTH-1:0] r_event;

    // A set takes priority over a clear, so software never loses a change
    // that lands on the same cycle as its acknowledge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_event <= '0;
        end else begin
            r_event <= w_accept | (r_event & ~clear);
        end
    end

    assign event_flag = r_event;
`else
    // Without event support the clear input has no load.
    logic w_unused_clear;
    assign w_unused_clear = ^clear;
    assign event_flag     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_debounce
//  Purpose  : Self-checking bench for switch_debounce (WIDTH=8,
//             DEBOUNCE_CYCLES=16). A reference model derives the expected
//             outputs every cycle. The synchronised input is modelled as
//             din delayed by two edges. A channel flips when all of its last
//             DEBOUNCE_CYCLES delayed samples differ from its current level.
//             Expected outputs are queued and a monitor compares them on
//             the falling edge. Directed checks cover the latencies named
//             in the test plan.
//             Event expectations follow SWITCH_DEBOUNCE_EVENT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int c_W   = 8;
    localparam int c_N   = 16;
    localparam int c_LAT = c_N + 2;
`ifdef SWITCH_DEBOUNCE_EVENT_EN
    localparam logic c_EV = 1'b1;
`else
    localparam logic c_EV = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstN = 1'b0;
    logic [c_W-1:0] din = '0;
    logic [c_W-1:0] clear = '0;
    logic [c_W-1:0] dout;
    logic [c_W-1:0] rise;
    logic [c_W-1:0] fall;
    logic [c_W-1:0] event_flag;
    logic           clr_rand = 1'b0;

    int errors = 0;
    int checks = 0;

    switch_debounce #(
        .WIDTH           (c_W),
        .DEBOUNCE_CYCLES (c_N)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .din        (din),
        .clear      (clear),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .event_flag (event_flag)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [c_W-1:0]  m_dout  = '0;
    logic [c_W-1:0]  m_event = '0;
    logic [c_W-1:0]  m_sync_q[$];
    logic [c_W-1:0]  m_hist[$];
    logic [31:0]     exp_q[$];

    always @(posedge clk or negedge rstN) begin
        logic [c_W-1:0] s2_pre;
        logic [c_W-1:0] flip;
        logic [c_W-1:0] e_rise;
        logic [c_W-1:0] e_fall;
        bit             all_diff;
        if (!rstN) begin
            m_dout   = '0;
            m_event  = '0;
            m_sync_q = '{8'h00, 8'h00};
            m_hist.delete();
            exp_q.delete();
            exp_q.push_back(32'h0);
        end else begin
            if (m_sync_q.size() != 2) m_sync_q = '{8'h00, 8'h00};
            s2_pre = m_sync_q.pop_front();
            m_sync_q.push_back(din);
            m_hist.push_back(s2_pre);
            if (m_hist.size() > c_N) void'(m_hist.pop_front());
            flip = '0;
            if (m_hist.size() == c_N) begin
                for (int i = 0; i < c_W; i++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[j]) if (m_hist[j][i] == m_dout[i]) all_diff = 1'b0;
                    flip[i] = all_diff;
                end
            end
            e_rise = flip & s2_pre;
            e_fall = flip & ~s2_pre;
            m_dout = m_dout ^ flip;
`ifdef SWITCH_DEBOUNCE_EVENT_EN
            m_event = flip | (m_event & ~clear);
`else
            m_event = '0;
`endif
            exp_q.push_back({m_dout, e_rise, e_fall, m_event});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dout, rise, fall, event_flag};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t actual {dout,rise,fall,event}=%h required=%h",
                         $time, a, e);
            end
        end
    end

    // Random clear driver used while clr_rand is set.
    always @(posedge clk) begin
        #2;
        if (clr_rand) clear = 8'($urandom);
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Count edges until dout[ch] reaches lvl (bounded), return at posedge+2.
    task automatic wait_level(input int ch, input logic lvl, output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (dout[ch] === lvl) break;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [c_W-1:0] tog;
        int rate;

        // Reset with all inputs high.
        din   = 8'hFF;
        clear = '0;
        rstN  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs_zero", {dout, rise, fall, event_flag}, 32'h0);
        rstN = 1'b1;
        wait_level(0, 1'b1, n);
        check("reset_release_latency", 32'(n), 32'(c_LAT));
        check("reset_release_dout", 32'(dout), 32'hFF);
        check("reset_release_rise", 32'(rise), 32'hFF);
        tick();
        check("reset_rise_width", 32'(rise), 32'h0);
        check("reset_event", 32'(event_flag), c_EV ? 32'hFF : 32'h0);

        // Return every channel low.
        din = '0;
        repeat (c_LAT + 4) tick();
        check("settle_low", 32'(dout), 32'h0);

        // Clean step on channel 0, with random clear activity.
        clr_rand = 1'b1;
        din[0]   = 1'b1;
        wait_level(0, 1'b1, n);
        check("step_latency", 32'(n), 32'(c_LAT));
        check("step_rise", 32'(rise), 32'h01);
        check("step_fall", 32'(fall), 32'h0);
        check("step_others", 32'(dout), 32'h01);
        tick();
        check("step_rise_width", 32'(rise), 32'h0);
`ifndef SWITCH_DEBOUNCE_EVENT_EN
        check("step_event_off", 32'(event_flag), 32'h0);
`endif
        clr_rand = 1'b0;
        clear    = '0;

        // Bounce on channel 3: 8 toggles, 5 cycles apart, then hold high.
        for (int k = 0; k < 8; k++) begin
            din[3] = ~din[3];
            repeat (5) tick();
        end
        check("bounce_no_change", 32'(dout[3]), 32'h0);
        din[3] = 1'b1;
        wait_level(3, 1'b1, n);
        check("bounce_final_latency", 32'(n), 32'(c_LAT));
        din[3] = 1'b0;
        wait_level(3, 1'b0, n);
        check("bounce_fall_latency", 32'(n), 32'(c_LAT));

        // A 15-cycle glitch is rejected.
        din[3] = 1'b1;
        repeat (15) tick();
        din[3] = 1'b0;
        repeat (c_LAT + 4) tick();
        check("glitch15_rejected", 32'(dout[3]), 32'h0);

        // A 16-cycle pulse is accepted, then falls again.
        din[3] = 1'b1;
        repeat (16) tick();
        din[3] = 1'b0;
        wait_level(3, 1'b1, n);
        check("pulse16_rise", 32'(n), 32'd2);
        wait_level(3, 1'b0, n);
        check("pulse16_fall", 32'(n), 32'd16);

        // Event and clear collision on channel 5.
        din[5] = 1'b1;
        wait_level(5, 1'b1, n);
        tick();
        check("event_set", 32'(event_flag[5]), 32'(c_EV));
        din[5] = 1'b0;
        repeat (c_LAT - 1) tick();
        clear[5] = 1'b1;
        tick();
        check("collision_dout", 32'(dout[5]), 32'h0);
        check("collision_fall", 32'(fall[5]), 32'h1);
        check("collision_set_wins", 32'(event_flag[5]), 32'(c_EV));
        clear[5] = 1'b0;
        tick();
        clear[5] = 1'b1;
        tick();
        check("clear_alone", 32'(event_flag[5]), 32'h0);
        clear[5] = 1'b0;

        // Reset in the middle of a count on channel 2.
        din[2] = 1'b1;
        repeat (12) tick();
        rstN = 1'b0;
        tick();
        check("midreset_outputs", {dout, rise, fall, event_flag}, 32'h0);
        tick();
        rstN = 1'b1;
        wait_level(2, 1'b1, n);
        check("midreset_latency", 32'(n), 32'(c_LAT));

        // Random traffic. The toggle rate is high at first to give mostly
        // glitches, then low so that changes are accepted.
        for (int c = 0; c < 1500; c++) begin
            rate = (c < 750) ? 11 : 40;
            for (int b = 0; b < c_W; b++) tog[b] = ($urandom_range(0, rate) == 0);
            din   = din ^ tog;
            clear = 8'($urandom) & 8'($urandom);
            tick();
        end
        clear = '0;
        repeat (c_LAT + 4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
